// File: rtl/run_monitor.sv
// run_monitor: sequences the core's reset, counts RUN cycles, shadows one
// architectural register from writeback, detects a PC self-loop as program
// halt and reports a pass / fail / timeout verdict.
module run_monitor #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_IDX_WIDTH  = 5,
  parameter int COUNT_WIDTH    = 16,
  parameter int RESET_CYCLES   = 2,
  parameter int HALT_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1600
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [REG_IDX_WIDTH-1:0] exp_reg,
  input  logic [DATA_WIDTH-1:0]    exp_value,
  input  logic [ADDR_WIDTH-1:0]    pc,
  input  logic                     wb_valid,
  input  logic [REG_IDX_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     cpu_reset,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timed_out,
  output logic [COUNT_WIDTH-1:0]   cycle_count,
  output logic [DATA_WIDTH-1:0]    observed
);

  localparam int HOLD_W   = $clog2(RESET_CYCLES + 1);
  localparam int STABLE_W = $clog2(HALT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    RESET_HOLD,
    RUN,
    CHECK,
    DONE
  } stateT;

  stateT                     state, stateNext;
  logic [HOLD_W-1:0]         holdCnt, holdCntNext;
  logic [STABLE_W-1:0]       stableCnt, stableCntNext;
  logic [ADDR_WIDTH-1:0]     prevPc, prevPcNext;
  logic                      prevPcValid, prevPcValidNext;
  logic [REG_IDX_WIDTH-1:0]  expReg, expRegNext;
  logic [DATA_WIDTH-1:0]     expValue, expValueNext;
  logic [COUNT_WIDTH-1:0]    countNext;
  logic [DATA_WIDTH-1:0]     observedNext;
  logic                      passNext, timedOutNext;
  logic                      pcSame, haltNow, shadowHit;

  assign pcSame    = prevPcValid && (pc == prevPc);
  assign haltNow   = pcSame && (stableCnt == STABLE_W'(HALT_CYCLES - 2));
  assign shadowHit = wb_valid && (wb_rd == expReg) && (wb_rd != '0);

  // Next-state and next-value logic for every register; outputs are derived from the next state so they stay registered
  always_comb begin
    stateNext       = state;
    holdCntNext     = holdCnt;
    stableCntNext   = stableCnt;
    prevPcNext      = prevPc;
    prevPcValidNext = prevPcValid;
    expRegNext      = expReg;
    expValueNext    = expValue;
    countNext       = cycle_count;
    observedNext    = observed;
    passNext        = pass;
    timedOutNext    = timed_out;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          expRegNext      = exp_reg;
          expValueNext    = exp_value;
          countNext       = '0;
          observedNext    = '0;
          passNext        = 1'b0;
          timedOutNext    = 1'b0;
          holdCntNext     = '0;
          stableCntNext   = '0;
          prevPcValidNext = 1'b0;
          stateNext       = RESET_HOLD;
        end
      end
      RESET_HOLD: begin
        if (holdCnt == HOLD_W'(RESET_CYCLES - 1)) begin
          stateNext = RUN;
        end else begin
          holdCntNext = holdCnt + 1'b1;
        end
      end
      RUN: begin
        countNext       = cycle_count + 1'b1;
        prevPcNext      = pc;
        prevPcValidNext = 1'b1;
        if (shadowHit) begin
          observedNext = wb_data;
        end
        if (pcSame) begin
          stableCntNext = stableCnt + 1'b1;
        end else begin
          stableCntNext = '0;
        end
        if (haltNow) begin
          stateNext = CHECK;
        end else if (cycle_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          timedOutNext = 1'b1;
          passNext     = 1'b0;
          stateNext    = DONE;
        end
      end
      CHECK: begin
        passNext     = (observed == expValue);
        timedOutNext = 1'b0;
        stateNext    = DONE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      holdCnt     <= '0;
      stableCnt   <= '0;
      prevPc      <= '0;
      prevPcValid <= 1'b0;
      expReg      <= '0;
      expValue    <= '0;
      cycle_count <= '0;
      observed    <= '0;
      pass        <= 1'b0;
      timed_out   <= 1'b0;
      cpu_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= stateNext;
      holdCnt     <= holdCntNext;
      stableCnt   <= stableCntNext;
      prevPc      <= prevPcNext;
      prevPcValid <= prevPcValidNext;
      expReg      <= expRegNext;
      expValue    <= expValueNext;
      cycle_count <= countNext;
      observed    <= observedNext;
      pass        <= passNext;
      timed_out   <= timedOutNext;
      cpu_reset   <= (stateNext != RUN);
      busy        <= (stateNext == RESET_HOLD) || (stateNext == RUN) || (stateNext == CHECK);
      done        <= (stateNext == DONE);
    end
  end

endmodule

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run controller and self-checker for the single-cycle RISC-V core.
- Sequences the core's reset and counts cycles. Snoops writeback for one architectural register and detects program halt (PC self-loop).
- Issues a pass/fail/timeout verdict.
- Replaces fixed-delay simulation runs: the bench or FPGA wrapper asserts start and waits for done.

Parameters:
- ADDR_WIDTH, 32, PC width.
- DATA_WIDTH, 32, writeback data width.
- REG_IDX_WIDTH, 5, register index width (32 registers).
- COUNT_WIDTH, 16, cycle counter width.
- RESET_CYCLES, 2, cycles the core is held in reset after start (≥1).
- HALT_CYCLES, 4, consecutive cycles with unchanged PC that mean halt (≥2).
- TIMEOUT_CYCLES, 1600, RUN cycles before timeout (< 2^COUNT_WIDTH).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  pulse: begin a run (honoured only in IDLE or DONE).
- exp_reg  input  REG_IDX_WIDTH  register to check; latched on accepted start.
- exp_value  input  DATA_WIDTH  expected final value; latched on accepted start.
- pc  input  ADDR_WIDTH  core fetch PC.
- wb_valid  input  1  core register write enable this cycle.
- wb_rd  input  REG_IDX_WIDTH  core destination register.
- wb_data  input  DATA_WIDTH  core writeback data.
- cpu_reset  output  1  active-high reset to core top.
- busy  output  1  high in RESET_HOLD, RUN, CHECK.
- done  output  1  verdict valid.
- pass  output  1  final value matched (valid when done).
- timed_out  output  1  run ended by timeout (valid when done).
- cycle_count  output  COUNT_WIDTH  RUN cycles elapsed.
- observed  output  DATA_WIDTH  shadow of checked register.

Behaviour:
- Reset (reset==0 at clock edge):
  - state=IDLE, cpu_reset=1, busy=0, done=0, pass=0, timed_out=0, cycle_count=0, observed=0.
  - Halt counter and prev_pc_valid cleared.
  - Reset overrides everything, including mid-run.
- States: IDLE, RESET_HOLD, RUN, CHECK, DONE. All outputs registered.
- IDLE:
  - cpu_reset=1.
  - start=1: latch exp_reg/exp_value; clear cycle_count, observed, done, pass, timed_out; go to RESET_HOLD.
- RESET_HOLD:
  - cpu_reset=1 for exactly RESET_CYCLES cycles, then RUN.
  - cpu_reset=0 from the first RUN cycle.
- RUN:
  - cycle_count increments by 1 each cycle.
  - Shadow: wb_valid=1 and wb_rd==latched exp_reg and wb_rd!=0 -> observed<=wb_data. Last write wins. Writes to x0 never update observed.
  - Halt detect: first RUN cycle only samples pc into prev_pc (prev_pc_valid=1, stable=0).
  - Halt detect, each later cycle: pc==prev_pc -> stable+1, else stable=0. prev_pc<=pc.
  - stable reaching HALT_CYCLES-1 -> CHECK. This is HALT_CYCLES consecutive equal PC samples.
  - Timeout: cycle_count==TIMEOUT_CYCLES-1 in a cycle with no halt -> DONE, timed_out=1, pass=0.
  - Halt and timeout in the same cycle -> halt wins (CHECK).
  - A writeback in the halt-detect cycle is captured before CHECK.
- CHECK:
  - One cycle; cpu_reset=1 from this cycle onward.
  - pass <= (observed==exp_value); go to DONE.
- DONE:
  - done=1, busy=0, cpu_reset=1.
  - pass, timed_out, cycle_count, observed held stable.
  - start=1: same actions as IDLE start; done drops the next cycle.
- start while busy is ignored, with no relatch.
- cycle_count never wraps: the timeout guarantees the bound.
- Latency:
  - start -> cpu_reset falls after RESET_CYCLES+1 edges.
  - Halt detect -> done is 2 edges.

Test Plan:
- GCD program (defaults), exp_reg=9, exp_value=0x10, core loops at its final PC -> done=1, pass=1, timed_out=0, observed=0x10. cycle_count equals RUN cycles counted by the bench.
- Same run with exp_value=0x11 -> done=1, pass=0, timed_out=0, observed=0x10.
- PC incrementing forever, TIMEOUT_CYCLES=20 -> done asserted exactly 21 edges after cpu_reset falls, with timed_out=1, pass=0, cycle_count=20 (0x0014).
- exp_reg=0, exp_value=0, stimulus writes wb_rd=0/wb_data=0xDEADBEEF, then halt -> observed=0, pass=1. Also: write x9=5 then x9=7 in consecutive cycles -> observed=7.
- Mid-RUN reset=0 for one edge -> next cycle state IDLE, cpu_reset=1, busy=0, all outputs 0. A start pulse during RUN has no effect: exp_value unchanged, cycle_count continues.
- PC held constant from cycle TIMEOUT_CYCLES-HALT_CYCLES so halt and timeout coincide -> pass verdict path taken, timed_out=0. Restart from DONE clears done the next cycle and reasserts cpu_reset for RESET_CYCLES cycles.
